// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM states and memory depth for the load/store unit
package lsu_pkg;
  localparam int MEM_WORDS_DEF = 1024;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} lsu_state_e;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extraction/extension for loads and lane merge for sub-word stores
module lsu_lane_align import lsu_pkg::*; (
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);
  logic [4:0]  sh;
  logic [31:0] lane;
  logic [31:0] mask;
  always_comb begin
    sh = {offset, 3'b000};
    lane = rdata >> sh;
    mask = size == SZ_BYTE ? 32'h0000_00ff << sh : size == SZ_HALF ? 32'h0000_ffff << sh : 32'hffff_ffff;
    load_data = size == SZ_BYTE ? {{24{sign_ext & lane[7]}}, lane[7:0]} :
                size == SZ_HALF ? {{16{sign_ext & lane[15]}}, lane[15:0]} : rdata;
    merge_data = (rdata & ~mask) | ((wdata << sh) & mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator for the word-only data memory with sub-word read-modify-write
module load_store_unit import lsu_pkg::*; #(
  parameter int MEM_WORDS  = MEM_WORDS_DEF,
  parameter int WORD_IDX_W = $clog2(MEM_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy,
  output logic        mem_write_enable,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);
  lsu_state_e state, next;
  logic                  write_q, sign_q, err_q;
  logic [1:0]            size_q;
  logic [WORD_IDX_W+1:0] addr_q;
  logic [31:0]           wdata_q, merge_q, rdata_q, load_data, merge_data;
  logic                  accept, req_err, word_wr;
  assign req_ready = state == IDLE;
  assign accept = req_valid & req_ready & ~rst;
  assign req_err = (req_size == 2'd3) | (req_size == SZ_HALF & req_addr[0]) |
                   (req_size == SZ_WORD & |req_addr[1:0]) | (req_addr >= 32'(4 * MEM_WORDS));
  assign word_wr = state == ACCESS & write_q & size_q == SZ_WORD;
  assign resp_valid = state == RESP;
  assign resp_error = resp_valid & err_q;
  assign resp_rdata = rdata_q;
  assign busy = state != IDLE | accept;
  // Gated by rst so an aborted read-modify-write never lands in memory.
  assign mem_write_enable = ~rst & (word_wr | state == MERGE_WR);
  assign mem_address = {{(32-WORD_IDX_W){1'b0}}, addr_q[WORD_IDX_W+1:2]};
  assign mem_write_data = state == MERGE_WR ? merge_q : word_wr ? wdata_q : 32'd0;
  lsu_lane_align u_align (
    .size       (size_q),
    .sign_ext   (sign_q),
    .offset     (addr_q[1:0]),
    .rdata      (mem_read_data),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );
  always_comb begin
    next = state;
    unique case (state)
      IDLE:     next = accept ? (req_err ? RESP : ACCESS) : IDLE;
      ACCESS:   next = write_q && size_q != SZ_WORD ? MERGE_WR : RESP;
      MERGE_WR: next = RESP;
      RESP:     next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      write_q <= 1'b0;
      sign_q <= 1'b0;
      err_q <= 1'b0;
      size_q <= 2'd0;
      addr_q <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= next;
      if (accept) begin
        write_q <= req_write;
        sign_q <= req_signed;
        err_q <= req_err;
        size_q <= req_size;
        addr_q <= req_addr[WORD_IDX_W+1:0];
        wdata_q <= req_wdata;
        rdata_q <= '0;
      end
      if (state == ACCESS) begin
        if (!write_q) rdata_q <= load_data;
        merge_q <= merge_data;
      end
    end
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Pipeline-side initiator for the 1024-word data memory of the MIPS datapath. It sits in the MEM stage.
- Accepts one load/store request at a time from the pipeline and converts byte addresses to word indices.
- Performs byte/halfword/word loads with sign or zero extension. Sub-word stores use read-modify-write on the word-only memory.
- Returns a one-cycle response and holds busy (stall) while a request is in flight.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the data memory; legal byte range is 0 .. 4*MEM_WORDS-1.
- WORD_IDX_W, 10, log2(MEM_WORDS); width of the word index driven on mem_address.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_signed  in  1  load extension: 1 = sign-extend, 0 = zero-extend; ignored for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low bits are used for byte and half stores.
- resp_valid  out  1  one-cycle pulse marking request completion.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  valid with resp_valid: misaligned, out-of-range or reserved size.
- busy  out  1  high from the accept cycle until the cycle resp_valid is asserted, inclusive.
- mem_write_enable  out  1  to the data memory; the write commits at the clock edge.
- mem_address  out  32  word index {zeros, req_addr[WORD_IDX_W+1:2]}.
- mem_write_data  out  32  full word to write.
- mem_read_data  in  32  combinational read of data[mem_address].

Behaviour:
- Reset values: state = IDLE; req_ready = 1; resp_valid = 0; resp_rdata = 0; resp_error = 0; busy = 0; mem_write_enable = 0; mem_address = 0; mem_write_data = 0.
- mem_write_enable is decoded from state and gated by ~rst, so no write is issued in any reset cycle.
- rst mid-operation aborts the request: no response is produced and state returns to IDLE at that edge.
- Byte lanes are little-endian: lane k = bits 8k+7:8k, selected by addr[1:0]. A halfword uses lanes addr[1]*2 .. addr[1]*2+1.
- Error conditions:
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr >= 4*MEM_WORDS;
  - req_size = 3.
  - An erroring request does no memory access; mem_write_enable is never asserted for it.
- FSM states: IDLE, ACCESS, MERGE_WR, RESP.
  - IDLE: on accept, latch all req_* fields and the error flag, then go to ACCESS (busy = 1). If error, go to RESP directly.
  - ACCESS: drive mem_address.
    - Load: capture the extended lane data into resp_rdata, go to RESP.
    - Word store: mem_write_enable = 1 with req_wdata, go to RESP.
    - Sub-word store: latch mem_read_data with the new lane(s) merged into a merge register, go to MERGE_WR.
  - MERGE_WR: mem_write_enable = 1, mem_write_data = merge register, same address; go to RESP.
  - RESP: resp_valid = 1 for one cycle with resp_rdata / resp_error, busy = 1; go to IDLE (req_ready = 1 next cycle).
- Latency, with accept at cycle T:
  - load and word store: resp_valid at T+2;
  - sub-word store: resp_valid at T+3;
  - error: resp_valid at T+1.
- Back-to-back: a new request can be accepted in the cycle after RESP. A store followed by a load to the same word returns the new data, because the write committed before the load's ACCESS.
- req_* inputs are sampled only at accept; later changes are ignored.
- Extension: byte sign bit = bit 7 of the lane; half sign bit = bit 15 of the half. Zero-extend fills the upper bits with 0.

Decomposition:
- Shared package (lsu_pkg): size encodings SZ_BYTE/SZ_HALF/SZ_WORD, the FSM state enumeration, and a MEM_WORDS default shared with the data memory.
- One natural sub-module: lsu_lane_align. It is purely combinational and performs load-lane extraction/extension plus store-lane merge.

Test Plan:
- Word store then load: sw 0xDEADBEEF @0x10, then lw @0x10 -> mem word 4 = 0xDEADBEEF; load resp_rdata = 0xDEADBEEF, resp_error = 0, resp_valid at T+2 each.
- Sub-word store RMW: word 4 = 0x11223344, sb 0xAA @0x13 -> word 4 = 0xAA223344; then sh 0xBEEF @0x10 -> 0xAA22BEEF; resp_valid at T+3; exactly one write pulse per store.
- Load extension: word 4 = 0x80FF7F01. lb @0x12 (signed) -> 0xFFFFFFFF; lbu @0x12 -> 0x000000FF; lh @0x12 signed -> 0xFFFF80FF; lhu @0x10 -> 0x00007F01.
- Errors: lw @0x06, lh @0x11, lw @0x1000, size = 3 -> resp_valid at T+1 with resp_error = 1, resp_rdata = 0; mem_write_enable stays 0; target memory is unchanged.
- Handshake: hold req_valid high for 3 back-to-back loads -> req_ready low while busy; each load is accepted exactly once; responses are in order, one pulse each.
- Reset mid-op: assert rst during MERGE_WR of sb @0x20 -> no write at that edge, memory word unchanged, no resp_valid; all outputs at reset values the next cycle.
